// File: rtl/drink_reminder_ctrl.sv
// drink_reminder_ctrl
//
// Sequencer and reminder scheduler for the water-bottle monitor. It sits
// downstream of the debounced level checker.
//   - A free-running prescaler produces a one-cycle sample strobe.
//   - On each strobe the debounced level is compared with the previous
//     sample. A large enough decrease counts as a drink.
//   - A four-state machine (INIT/MONITOR/REMIND/SNOOZE) drives the
//     user-facing reminder output.
//
// Optional build macro EMPTY_ALERT_EN:
//   When defined, empty is registered on every strobe as (water_level == 0).
//   While the machine is in REMIND or SNOOZE, empty forces reminder high.
//   When undefined, empty is tied low and no empty-compare logic exists.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   water_level  in   [3:0] debounced water level
//   ack          in   acknowledge/snooze button, synchronous level
//   sample_tick  out  one-cycle strobe marking the level sample point
//   reminder     out  high while reminding
//   drink_count  out  [7:0] drinks since reset, saturating at 255
//   state        out  [1:0] INIT=0, MONITOR=1, REMIND=2, SNOOZE=3
//   empty        out  bottle-empty indication
module drink_reminder_ctrl #(
    parameter int unsigned SAMPLE_DIV     = 50000000,
    parameter int unsigned REMIND_SAMPLES = 3600,
    parameter int unsigned SNOOZE_SAMPLES = 600,
    parameter int unsigned MIN_DROP       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] water_level,
    input  logic       ack,
    output logic       sample_tick,
    output logic       reminder,
    output logic [7:0] drink_count,
    output logic [1:0] state,
    output logic       empty
);

    localparam int unsigned PresWidth = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned IdleMax   = (REMIND_SAMPLES > SNOOZE_SAMPLES) ?
                                        REMIND_SAMPLES : SNOOZE_SAMPLES;
    localparam int unsigned IdleWidth = (IdleMax > 1) ? $clog2(IdleMax) : 1;

    localparam logic [PresWidth-1:0] PresLast   = PresWidth'(SAMPLE_DIV - 1);
    localparam logic [IdleWidth-1:0] RemindLast = IdleWidth'(REMIND_SAMPLES - 1);
    localparam logic [IdleWidth-1:0] SnoozeLast = IdleWidth'(SNOOZE_SAMPLES - 1);
    localparam logic [4:0]           MinDrop    = 5'(MIN_DROP);

    typedef enum logic [1:0] {
        StInit    = 2'd0,
        StMonitor = 2'd1,
        StRemind  = 2'd2,
        StSnooze  = 2'd3
    } state_e;

    logic [PresWidth-1:0] presc_q, presc_d;
    logic                 tick_q, tick_d;
    state_e               state_q, state_d;
    logic [IdleWidth-1:0] idle_q, idle_d;
    logic [3:0]           last_q, last_d;
    logic [7:0]           count_q, count_d;
    logic                 reminder_q, reminder_d;
    logic                 empty_d;

    // Drink detection. The 5-bit difference is only trusted when the level
    // actually fell, so a refill can never wrap into a false drink.
    logic [4:0] drop;
    logic       drink;

    assign drop  = {1'b0, last_q} - {1'b0, water_level};
    assign drink = tick_q && (state_q != StInit) && (water_level < last_q) &&
                   (drop >= MinDrop);

    // Prescaler, sample strobe, baseline level and drink counter.
    always_comb begin
        presc_d = (presc_q == PresLast) ? '0 : presc_q + PresWidth'(1);
        tick_d  = (presc_q == PresLast);
        last_d  = tick_q ? water_level : last_q;
        count_d = (drink && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
    end

    // Reminder state machine. idle_q counts drink-free strobes in MONITOR
    // and SNOOZE. It is cleared on every state change, so it stays below
    // IdleMax.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            StInit: begin
                // The first strobe only captures the baseline level.
                if (tick_q) begin
                    state_d = StMonitor;
                    idle_d  = '0;
                end
            end
            StMonitor: begin
                if (tick_q) begin
                    if (drink) begin
                        idle_d = '0;
                    end else if (idle_q == RemindLast) begin
                        state_d = StRemind;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IdleWidth'(1);
                    end
                end
            end
            StRemind: begin
                // A drink on the same cycle as ack takes priority over the snooze.
                if (drink) begin
                    state_d = StMonitor;
                    idle_d  = '0;
                end else if (ack) begin
                    state_d = StSnooze;
                    idle_d  = '0;
                end
            end
            StSnooze: begin
                if (drink) begin
                    state_d = StMonitor;
                    idle_d  = '0;
                end else if (tick_q) begin
                    if (idle_q == SnoozeLast) begin
                        state_d = StRemind;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IdleWidth'(1);
                    end
                end
            end
            default: begin
                state_d = StInit;
                idle_d  = '0;
            end
        endcase
    end

`ifdef EMPTY_ALERT_EN
    logic empty_q;

    always_comb begin
        empty_d = tick_q ? (water_level == 4'd0) : empty_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            empty_q <= 1'b0;
        end else begin
            empty_q <= empty_d;
        end
    end

    assign empty = empty_q;
`else
    assign empty_d = 1'b0;
    assign empty   = 1'b0;
`endif

    // Reminder is registered from the next state, so it moves on the same
    // edge as state. An empty bottle keeps a snoozed reminder sounding.
    always_comb begin
        reminder_d = (state_d == StRemind) || (empty_d && (state_d == StSnooze));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            state_q    <= StInit;
            idle_q     <= '0;
            last_q     <= 4'd0;
            count_q    <= 8'd0;
            reminder_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            state_q    <= state_d;
            idle_q     <= idle_d;
            last_q     <= last_d;
            count_q    <= count_d;
            reminder_q <= reminder_d;
        end
    end

    assign sample_tick = tick_q;
    assign reminder    = reminder_q;
    assign drink_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_drink_reminder_ctrl.sv
// Self-checking bench for drink_reminder_ctrl with SAMPLE_DIV=4,
// REMIND_SAMPLES=3, SNOOZE_SAMPLES=2 and MIN_DROP=1. Expected
// {state, reminder, empty, drink_count} words are queued when stimulus is
// applied. They are popped and compared once the strobe edge has passed.
module tb_drink_reminder_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] water_level = 4'd8;
    logic       ack = 1'b0;
    logic       sample_tick;
    logic       reminder;
    logic [7:0] drink_count;
    logic [1:0] state;
    logic       empty;

    drink_reminder_ctrl #(
        .SAMPLE_DIV    (4),
        .REMIND_SAMPLES(3),
        .SNOOZE_SAMPLES(2),
        .MIN_DROP      (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .water_level(water_level),
        .ack        (ack),
        .sample_tick(sample_tick),
        .reminder   (reminder),
        .drink_count(drink_count),
        .state      (state),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [11:0] val;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] obs;

    assign obs = {state, reminder, empty, drink_count};

    function automatic exp_t mk(string name, int st, int rem, int emp, int cnt);
        exp_t x;
        x.name = name;
        x.val  = {2'(st), 1'(rem), 1'(emp), 8'(cnt)};
        return x;
    endfunction

    // Park on the negedge before the next strobe edge (bounded wait).
    task automatic wait_tick();
        int n = 0;
        while (sample_tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (sample_tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout got=%b exp=1", sample_tick);
        end
    endtask

    task automatic tick();
        wait_tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int level);
        water_level = 4'(level);
        ack = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        water_level = 4'd8;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.push_back(mk("reset_values", 0, 0, 0, 0));
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        checks++;
        if (sample_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick got=%b exp=0", sample_tick);
        end
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (sample_tick !== (i % 4 == 0)) begin
                failures++;
                $display("FAIL tick_period[%0d] got=%b exp=%b", i, sample_tick, (i % 4 == 0));
            end
        end
    endtask

    task automatic test_remind_timeout();
        int lv [4] = '{8, 8, 8, 8};
        int st [4] = '{1, 1, 1, 2};
        int rm [4] = '{0, 0, 0, 1};
        do_reset(8);
        for (int i = 0; i < 4; i++) begin
            water_level = 4'(lv[i]);
            sb_q.push_back(mk("remind_timeout", st[i], rm[i], 0, 0));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, obs, e.val);
            end
        end
    endtask

    task automatic test_drink();
        int lv [5] = '{8, 6, 6, 6, 6};
        int st [5] = '{1, 1, 1, 1, 2};
        int rm [5] = '{0, 0, 0, 0, 1};
        int cn [5] = '{0, 1, 1, 1, 1};
        do_reset(8);
        for (int i = 0; i < 5; i++) begin
            water_level = 4'(lv[i]);
            sb_q.push_back(mk("drink_defers", st[i], rm[i], 0, cn[i]));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, obs, e.val);
            end
        end
    endtask

    // Continues from REMIND with drink_count=1 and the level at 6.
    task automatic test_snooze();
        ack = 1'b1;
        sb_q.push_back(mk("ack_to_snooze", 3, 0, 0, 1));
        @(negedge clk);
        ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        // ack is held high through the first snooze strobe and must be ignored.
        ack = 1'b1;
        sb_q.push_back(mk("snooze_ack_ignored", 3, 0, 0, 1));
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        sb_q.push_back(mk("snooze_expire", 2, 1, 0, 1));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
    endtask

    task automatic test_ack_drink();
        do_reset(5);
        repeat (4) tick();
        sb_q.push_back(mk("ack_drink_pre", 2, 1, 0, 0));
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        wait_tick();
        water_level = 4'd4;
        ack = 1'b1;
        sb_q.push_back(mk("ack_drink_same_cycle", 1, 0, 0, 1));
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        sb_q.push_back(mk("monitor_ack_ignored", 1, 0, 0, 1));
        tick();
        ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
    endtask

    task automatic test_refill_saturate();
        int lv [4] = '{3, 12, 12, 12};
        int st [4] = '{1, 1, 1, 2};
        int rm [4] = '{0, 0, 0, 1};
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            water_level = 4'(lv[i]);
            sb_q.push_back(mk("refill_keeps_idle", st[i], rm[i], 0, 0));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, obs, e.val);
            end
        end
        // 257 drinks, alternating a one-unit drop with a refill.
        for (int k = 1; k <= 257; k++) begin
            if (k > 1) begin
                water_level = 4'd12;
                tick();
            end
            water_level = 4'd11;
            if (k == 1 || k >= 254) sb_q.push_back(mk("drink_saturate", 1, 0, 0,
                                                      (k > 255) ? 255 : k));
            tick();
            if (k == 1 || k >= 254) begin
                e = sb_q.pop_front();
                checks++;
                if (obs !== e.val) begin
                    failures++;
                    $display("FAIL %s[%0d] got=%h exp=%h", e.name, k, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_in_snooze();
        int lv [5] = '{7, 6, 6, 6, 6};
        do_reset(7);
        for (int i = 0; i < 5; i++) begin
            water_level = 4'(lv[i]);
            tick();
        end
        ack = 1'b1;
        sb_q.push_back(mk("pre_reset_snooze", 3, 0, 0, 1));
        @(negedge clk);
        ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        reset = 1'b0;
        sb_q.push_back(mk("mid_reset", 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (sample_tick !== (i == 4 ? 1'b0 : 1'b0) && i < 4) begin
                failures++;
                $display("FAIL mid_reset_tick[%0d] got=%b exp=0", i, sample_tick);
            end
            @(negedge clk);
        end
        checks++;
        if (sample_tick !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_first_tick got=%b exp=1", sample_tick);
        end
        // Baseline after reset must not count a drink against the stale level.
        sb_q.push_back(mk("post_reset_baseline", 1, 0, 0, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
    endtask

`ifdef EMPTY_ALERT_EN
    task automatic test_empty();
        int st [4] = '{1, 1, 1, 2};
        int rm [4] = '{0, 0, 0, 1};
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(mk("empty_monitor", st[i], rm[i], 1, 0));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, obs, e.val);
            end
        end
        ack = 1'b1;
        sb_q.push_back(mk("empty_snooze_forced", 3, 1, 1, 0));
        @(negedge clk);
        ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        sb_q.push_back(mk("empty_snooze_tick", 3, 1, 1, 0));
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        water_level = 4'd9;
        sb_q.push_back(mk("empty_refill", 2, 1, 0, 0));
        tick();
        tick();
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
        ack = 1'b1;
        sb_q.push_back(mk("refilled_snooze_quiet", 3, 0, 0, 0));
        @(negedge clk);
        ack = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, obs, e.val);
        end
    endtask
`else
    task automatic test_empty();
        do_reset(0);
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(mk("empty_disabled", 1, 0, 0, 0));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (obs !== e.val) begin
                failures++;
                $display("FAIL %s[%0d] got=%h exp=%h", e.name, i, obs, e.val);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_remind_timeout();
        test_drink();
        test_snooze();
        test_ack_drink();
        test_refill_saturate();
        test_reset_in_snooze();
        test_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
